muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU that produces the HI/LO result pair.

---
 rtl/muldiv_ctrl_if.sv | 30 +++
 rtl/muldiv_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> HI/LO sequencer bundle: operation request, pipeline hold and result write port.
// Latency: none (wires only).
// Backpressure: stall_req from the sequencer holds the requester, which keeps start/op/operands steady.
interface muldiv_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  flush;
    logic                  stall_req;
    logic                  busy;
    logic                  we_hilo;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;
    logic                  div_zero;

    // EX stage side: issues the operation and consumes the HI/LO write.
    modport master (
        output start, op, src_a, src_b, flush,
        input  stall_req, busy, we_hilo, hi_out, lo_out, div_zero
    );

    // Sequencer side.
    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall_req, busy, we_hilo, hi_out, lo_out, div_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing {hi,lo} with a one-cycle we_hilo strobe.
// Latency: mult MUL_CYCLES+1, divide DATA_WIDTH+1, divide-by-zero 1 cycle after accept.
// Backpressure: stall_req holds IF/ID/EX from accept until the DONE cycle; flush aborts with no write.
module muldiv_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);
    localparam int W       = DATA_WIDTH;
    localparam int CNT_MAX = (MUL_CYCLES > DATA_WIDTH) ? MUL_CYCLES : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2*W-1:0]   prod_q,   prod_d;
    logic [W-1:0]     rem_q,    rem_d;
    logic [W-1:0]     quo_q,    quo_d;
    logic [W-1:0]     dvs_q,    dvs_d;
    logic             qneg_q,   qneg_d;
    logic             rneg_q,   rneg_d;
    logic [W-1:0]     hi_q,     hi_d;
    logic [W-1:0]     lo_q,     lo_d;
    logic             we_q,     we_d;
    logic             dz_q,     dz_d;
    logic             busy_q,   busy_d;

    // Operand preparation at accept: sign handling for signed ops.
    logic           is_signed;
    logic [W-1:0]   a_abs, b_abs;
    logic [2*W-1:0] ext_a, ext_b;

    always_comb begin
        is_signed = ~bus.op[0];
        a_abs     = (is_signed && bus.src_a[W-1]) ? -bus.src_a : bus.src_a;
        b_abs     = (is_signed && bus.src_b[W-1]) ? -bus.src_b : bus.src_b;
        ext_a     = is_signed ? {{W{bus.src_a[W-1]}}, bus.src_a} : {{W{1'b0}}, bus.src_a};
        ext_b     = is_signed ? {{W{bus.src_b[W-1]}}, bus.src_b} : {{W{1'b0}}, bus.src_b};
    end

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    logic [W:0]   shifted, diff;
    logic         fits;
    logic [W-1:0] step_rem, step_quo;

    always_comb begin
        shifted  = {rem_q, quo_q[W-1]};
        diff     = shifted - {1'b0, dvs_q};
        fits     = (shifted >= {1'b0, dvs_q});
        // The kept value is always below the divisor, so its top bit is zero.
        step_rem = W'(fits ? diff : shifted);
        step_quo = {quo_q[W-2:0], fits};
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    cnt_d = '0;
                    if (!bus.op[1]) begin
                        // Product is formed once here and released after the count.
                        prod_d  = ext_a * ext_b;
                        state_d = S_MUL;
                    end else if (bus.src_b == '0) begin
                        hi_d    = bus.src_a;
                        lo_d    = '1;
                        we_d    = 1'b1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        qneg_d  = is_signed && (bus.src_a[W-1] ^ bus.src_b[W-1]);
                        rneg_d  = is_signed && bus.src_a[W-1];
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    hi_d    = prod_q[2*W-1:W];
                    lo_d    = prod_q[W-1:0];
                    we_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == DIV_LAST) begin
                    // Sign fix-up: quotient by sign mismatch, remainder follows the dividend.
                    lo_d    = qneg_q ? -step_quo : step_quo;
                    hi_d    = rneg_q ? -step_rem : step_rem;
                    we_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Op already consumed; start seen here belongs to the same instruction.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush beats both a new accept and a completing op; the result registers stay put.
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            we_d    = 1'b0;
            dz_d    = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
        end
    end

    // The accept term must be combinational so EX freezes in the very cycle it presents the op.
    assign bus.stall_req = (state_q == S_IDLE && bus.start && !bus.flush && rst)
                         || (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.busy      = busy_q;
    assign bus.we_hilo   = we_q;
    assign bus.div_zero  = dz_q;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic model.
// Latency: expected strobe cycle comes from the model (MUL_CYCLES+1, W+1, or 1).
// Backpressure: start is held while stall_req is high and dropped in the write cycle.
module tb_muldiv_ctrl;
    localparam int W  = 32;
    localparam int MC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.DATA_WIDTH(W)) bus ();

    muldiv_ctrl #(.DATA_WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    int exp_strobes = 0;

    // Count every write strobe the DUT produces, to catch writes that should never happen.
    always @(negedge clk) if (bus.we_hilo === 1'b1) strobes++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit values.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output int lat);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0]        ua, ub, up, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        if (!op[1]) begin
            lat = MC + 1;
            if (op[0]) begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            else       begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
        end else if (b == 32'd0) begin
            lat = 1; lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
        end else begin
            lat = W + 1;
            if (op[0]) begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
            else       begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit chk_after);
        logic [31:0] ehi, elo;
        logic        edz;
        int          lat, k, stall_bad;
        bit          done;
        model(op, a, b, ehi, elo, edz, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.flush = 1'b0;
        #1 chk({tag, ":accept_stall"}, 64'(bus.stall_req), 64'd1);
        k = 0; stall_bad = 0; done = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                // Operands must have been captured at accept.
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
            if (bus.we_hilo === 1'b1) done = 1;
            else if (bus.stall_req !== 1'b1 || bus.busy !== 1'b1) stall_bad++;
        end
        chk({tag, ":latency"}, 64'(k), 64'(lat));
        chk({tag, ":stall_while_running"}, 64'(stall_bad), 64'd0);
        chk({tag, ":hi"}, 64'(bus.hi_out), 64'(ehi));
        chk({tag, ":lo"}, 64'(bus.lo_out), 64'(elo));
        chk({tag, ":div_zero"}, 64'(bus.div_zero), 64'(edz));
        chk({tag, ":stall_low_in_done"}, 64'(bus.stall_req), 64'd0);
        exp_strobes++;
        bus.start = 1'b0;
        if (chk_after) begin
            @(negedge clk);
            chk({tag, ":we_one_cycle"}, 64'(bus.we_hilo), 64'd0);
            chk({tag, ":dz_one_cycle"}, 64'(bus.div_zero), 64'd0);
            chk({tag, ":busy_after"}, 64'(bus.busy), 64'd0);
            chk({tag, ":hi_hold"}, 64'(bus.hi_out), 64'(ehi));
            chk({tag, ":lo_hold"}, 64'(bus.lo_out), 64'(elo));
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:busy", 64'(bus.busy), 64'd0);
        chk("rst:we", 64'(bus.we_hilo), 64'd0);
        chk("rst:hi", 64'(bus.hi_out), 64'd0);
        chk("rst:lo", 64'(bus.lo_out), 64'd0);
        chk("rst:dz", 64'(bus.div_zero), 64'd0);
        chk("rst:stall", 64'(bus.stall_req), 64'd0);
        rst = 1'b1;

        // Directed cases.
        do_op("multu_ffff_x2", 2'b01, 32'hFFFF_FFFF, 32'd2, 1);
        do_op("mult_neg3_x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1);
        do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1);
        do_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1);
        do_op("div_min_neg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        do_op("divu_9_0", 2'b11, 32'd9, 32'd0, 1);
        do_op("div_neg5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1);

        // Start together with flush in IDLE must not be accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd5; bus.src_b = 32'd6; bus.flush = 1'b1;
        #1 chk("flush_idle:stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        chk("flush_idle:busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b0; bus.flush = 1'b0;

        // DIVU flushed at t+10, then a fresh MULTU at t+12.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        bus.flush = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_div:busy", 64'(bus.busy), 64'd0);
        chk("flush_div:stall", 64'(bus.stall_req), 64'd0);
        chk("flush_div:we", 64'(bus.we_hilo), 64'd0);
        do_op("multu_3x4_after_flush", 2'b01, 32'd3, 32'd4, 1);

        // Reset in the middle of a DIV.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'hFFFF_FF9C; bus.src_b = 32'd7;
        for (int i = 1; i <= 5; i++) @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("rst_mid:busy", 64'(bus.busy), 64'd0);
        chk("rst_mid:stall", 64'(bus.stall_req), 64'd0);
        chk("rst_mid:we", 64'(bus.we_hilo), 64'd0);
        chk("rst_mid:hi", 64'(bus.hi_out), 64'd0);
        chk("rst_mid:lo", 64'(bus.lo_out), 64'd0);
        chk("rst_mid:dz", 64'(bus.div_zero), 64'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // Back-to-back: second op arrives the cycle after DONE.
        do_op("b2b_div", 2'b10, 32'd12345, 32'hFFFF_FFF6, 0);
        do_op("b2b_mult", 2'b00, 32'h8000_0000, 32'h8000_0000, 1);

        // Random ops, with an occasional zero divisor.
        for (int n = 0; n < 14; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            do_op("rand", rop, ra, rb, ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(negedge clk);
        chk("strobe_count", 64'(strobes), 64'(exp_strobes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
